// File: rtl/palindrome_pkg.sv
// Shared state encoding and mode constants for the palindrome checker.
package palindrome_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FIND    = 3'd1,
    COMPARE = 3'd2,
    DONE    = 3'd3
  } state_t;

  localparam logic MODE_FULL = 1'b0;
  localparam logic MODE_SIG  = 1'b1;

endpackage

// File: rtl/palindrome_checker_param_digit_sel.sv
// Combinational digit mux: picks digit `index_i` out of a WIDTH-bit word.
module palindrome_digit_sel #(
  parameter int WIDTH      = 32,
  parameter int DIGIT_BITS = 1,
  localparam int ND        = WIDTH / DIGIT_BITS,
  localparam int IW        = (ND > 1) ? $clog2(ND) : 1
) (
  input  logic [WIDTH-1:0]      word_i,
  input  logic [IW-1:0]         index_i,
  output logic [DIGIT_BITS-1:0] digit_o
);

  always_comb begin
    digit_o = '0;
    for (int k = 0; k < ND; k++) begin
      if (index_i == k[IW-1:0]) digit_o = word_i[k*DIGIT_BITS +: DIGIT_BITS];
    end
  end

endmodule

// File: rtl/palindrome_checker_param.sv
// Multi-cycle digit-string palindrome checker (full-width or significant digits).
// Optional macro PALINDROME_ABORT_EN: dropping go_i during FIND/COMPARE aborts to IDLE.
module palindrome_checker_param
  import palindrome_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DIGIT_BITS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] number_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             result_o,
  output logic [2:0]       state_o
);

  localparam int ND = WIDTH / DIGIT_BITS;
  localparam int IW = (ND > 1) ? $clog2(ND) : 1;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      num_q, num_d;
  logic [IW-1:0]         lo_q, lo_d;
  logic [IW-1:0]         hi_q, hi_d;
  logic                  result_q, result_d;
  logic [DIGIT_BITS-1:0] dig_lo, dig_hi;

  palindrome_digit_sel #(.WIDTH(WIDTH), .DIGIT_BITS(DIGIT_BITS)) u_sel_lo (
    .word_i  (num_q),
    .index_i (lo_q),
    .digit_o (dig_lo)
  );

  palindrome_digit_sel #(.WIDTH(WIDTH), .DIGIT_BITS(DIGIT_BITS)) u_sel_hi (
    .word_i  (num_q),
    .index_i (hi_q),
    .digit_o (dig_hi)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      num_q    <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      result_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        result_d = 1'b0;
        if (go_i) begin
          num_d   = number_i;
          lo_d    = '0;
          hi_d    = IW'(ND - 1);
          state_d = (mode_i == MODE_SIG) ? FIND : COMPARE;
        end
      end
      FIND: begin
        // Walk hi down past leading zero digits; hi == 0 stops on an all-zero word.
        if (dig_hi != '0 || hi_q == '0) state_d = COMPARE;
        else                            hi_d    = hi_q - 1'b1;
`ifdef PALINDROME_ABORT_EN
        if (!go_i) state_d = IDLE;
`endif
      end
      COMPARE: begin
        // Pointer-crossing test precedes any update, so lo/hi never wrap.
        if (lo_q >= hi_q) begin
          state_d  = DONE;
          result_d = 1'b1;
        end else if (dig_lo != dig_hi) begin
          state_d  = DONE;
          result_d = 1'b0;
        end else begin
          lo_d = lo_q + 1'b1;
          hi_d = hi_q - 1'b1;
        end
`ifdef PALINDROME_ABORT_EN
        if (!go_i) begin
          state_d  = IDLE;
          result_d = 1'b0;
        end
`endif
      end
      DONE: begin
        if (!go_i) begin
          state_d  = IDLE;
          result_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        result_d = 1'b0;
      end
    endcase
  end

  assign busy_o   = (state_q == FIND) || (state_q == COMPARE);
  assign done_o   = (state_q == DONE);
  assign result_o = result_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_palindrome_checker_param.sv
// Bench for palindrome_checker_param: 32x1-bit and 16x4-bit instances vs a digit-string model.
module tb_palindrome_checker_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        go32, mode32, busy32, done32, res32;
  logic [31:0] num32;
  logic [2:0]  st32;
  logic        go16, mode16, busy16, done16, res16;
  logic [15:0] num16;
  logic [2:0]  st16;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  palindrome_checker_param #(.WIDTH(32), .DIGIT_BITS(1)) dut32 (
    .clk(clk), .reset(reset), .go_i(go32), .mode_i(mode32), .number_i(num32),
    .busy_o(busy32), .done_o(done32), .result_o(res32), .state_o(st32)
  );

  palindrome_checker_param #(.WIDTH(16), .DIGIT_BITS(4)) dut16 (
    .clk(clk), .reset(reset), .go_i(go16), .mode_i(mode16), .number_i(num16),
    .busy_o(busy16), .done_o(done16), .result_o(res16), .state_o(st16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: view the word as a digit string, optionally drop leading zeros, compare ends inward.
  function automatic void model(input logic [31:0] num, input int nd, input int db, input bit mode,
                                output bit res, output int fc, output int cc);
    int d[32];
    int msd, len, m;
    msd = 0;
    for (int k = 0; k < nd; k++) begin
      d[k] = int'((num >> (k * db)) & ((32'd1 << db) - 1));
      if (d[k] != 0) msd = k;
    end
    len = mode ? msd + 1 : nd;
    fc  = mode ? (nd - 1 - msd) + 1 : 0;
    m = 0;
    while (m < len / 2 && d[m] == d[len - 1 - m]) m++;
    res = (m == len / 2);
    cc  = m + 1;
  endfunction

  function automatic logic [31:0] make_pal(input logic [31:0] r, input int nd, input int db, input int len);
    logic [31:0] v;
    logic [31:0] mask;
    int src;
    v = '0;
    mask = (32'd1 << db) - 1;
    for (int i = 0; i < len; i++) begin
      src = (i < len - 1 - i) ? i : len - 1 - i;
      v = v | (((r >> (src * db)) & mask) << (i * db));
    end
    return v;
  endfunction

  task automatic set_go(input bit sel, input logic v);
    if (sel) go16 = v; else go32 = v;
  endtask

  function automatic logic [2:0] st(input bit sel);
    return sel ? st16 : st32;
  endfunction

  function automatic logic dn(input bit sel);
    return sel ? done16 : done32;
  endfunction

  function automatic logic rs(input bit sel);
    return sel ? res16 : res32;
  endfunction

  // One full go/done handshake with latency, state-occupancy and result checks.
  task automatic run_op(input bit sel, input logic [31:0] num, input bit mode, input string tag);
    bit exp_res;
    int fc, cc, n, fcnt, ccnt;
    model(num, sel ? 4 : 32, sel ? 4 : 1, mode, exp_res, fc, cc);
    @(negedge clk);
    if (sel) begin num16 = num[15:0]; mode16 = mode; end
    else     begin num32 = num;       mode32 = mode; end
    set_go(sel, 1'b1);
    @(posedge clk); #1;
    if (sel) begin num16 = 16'($urandom); mode16 = ~mode; end
    else     begin num32 = $urandom;      mode32 = ~mode; end
    n = 0; fcnt = 0; ccnt = 0;
    while (!dn(sel) && n < 300) begin
      if (st(sel) == 3'd1) fcnt++;
      if (st(sel) == 3'd2) ccnt++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, fc + cc);
    check({tag, "_find_cycles"}, fcnt, fc);
    check({tag, "_cmp_cycles"}, ccnt, cc);
    check({tag, "_result"}, rs(sel), exp_res);
    check({tag, "_state_done"}, st(sel), 3'd3);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_done_hold"}, {dn(sel), rs(sel)}, {1'b1, exp_res});
    @(negedge clk);
    set_go(sel, 1'b0);
    @(posedge clk); #1;
    check({tag, "_idle_after"}, {st(sel), dn(sel), rs(sel)}, {3'd0, 1'b0, 1'b0});
  endtask

  initial begin
    logic [31:0] r, v;
    bit   md, sel, sawdone;
    int   len;
    reset = 1'b1;
    go32 = 1'b0; mode32 = 1'b0; num32 = '0;
    go16 = 1'b0; mode16 = 1'b0; num16 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_32", {st32, busy32, done32, res32}, {3'd0, 3'b000});
    check("reset_16", {st16, busy16, done16, res16}, {3'd0, 3'b000});
    @(negedge clk);
    reset = 1'b0;

    // Directed cases
    run_op(1'b0, 32'h0000_00B5, 1'b1, "b5_sig");
    run_op(1'b0, 32'h0000_00A5, 1'b1, "a5_sig");
    run_op(1'b0, 32'h0000_00A5, 1'b0, "a5_full");
    run_op(1'b0, 32'h0000_0000, 1'b1, "zero_sig");
    run_op(1'b0, 32'h8000_0001, 1'b0, "ends_full");
    run_op(1'b0, 32'hFFFF_FFFF, 1'b0, "ones_full");
    run_op(1'b1, 32'h0000_1221, 1'b0, "h1221_full");
    run_op(1'b1, 32'h0000_0121, 1'b1, "h0121_sig");
    run_op(1'b1, 32'h0000_0121, 1'b0, "h0121_full");
    run_op(1'b1, 32'h0000_0000, 1'b1, "h0_sig");

    // Randomized cases, half of them constructed palindromes
    for (int i = 0; i < 24; i++) begin
      sel = i[0];
      md  = $urandom_range(0, 1);
      r   = $urandom;
      if (i[1]) begin
        len = sel ? $urandom_range(1, 4) : $urandom_range(1, 32);
        v = make_pal(r, sel ? 4 : 32, sel ? 4 : 1, len);
      end else begin
        v = sel ? {16'd0, r[15:0]} : (r >> $urandom_range(0, 31));
      end
      run_op(sel, v, md, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of COMPARE
    @(negedge clk);
    num32 = 32'hFFFF_FFFF; mode32 = 1'b0; go32 = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    check("pre_reset_busy", {st32, busy32}, {3'd2, 1'b1});
    reset = 1'b1;
    #1;
    check("async_reset", {st32, busy32, done32, res32}, {3'd0, 3'b000});
    go32 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sawdone = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done32) sawdone = 1'b1;
    end
    check("no_done_after_reset", sawdone, 1'b0);

    // go_i dropped during FIND
    @(negedge clk);
    num32 = 32'h0000_0001; mode32 = 1'b1; go32 = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("abort_in_find", st32, 3'd1);
    @(negedge clk);
    go32 = 1'b0;
`ifdef PALINDROME_ABORT_EN
    @(posedge clk); #1;
    check("abort_idle", {st32, busy32}, {3'd0, 1'b0});
    sawdone = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32) sawdone = 1'b1;
    end
    check("abort_no_done", sawdone, 1'b0);
    check("abort_result", res32, 1'b0);
`else
    sawdone = 1'b0;
    for (int n = 0; n < 60 && !sawdone; n++) begin
      @(posedge clk); #1;
      if (done32) begin
        sawdone = 1'b1;
        check("noabort_result", res32, 1'b1);
      end
    end
    check("noabort_done", sawdone, 1'b1);
    @(posedge clk); #1;
    check("noabort_idle", {st32, done32}, {3'd0, 1'b0});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
